// File: rtl/mem_responder.sv
// Single-port word RAM behind a valid/ready request/response handshake with a configurable wait-state delay.
// Optional LED register at addr[31]==1 when MEM_RESPONDER_IO_EN is defined.
module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   input  logic        resp_ready,
   output logic [3:0]  leds
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q;
   logic          ready_q;
   logic          valid_q;
   logic [31:0]   rdata_q;
   logic [3:0]    cnt_q;
   logic [AW-1:0] idx_q;
   logic          read_q;
   logic          io_q;

   logic [31:0]   ram_q [DEPTH_WORDS];

   logic          accept;
   logic [AW-1:0] acc_idx;
   logic          acc_io;
   logic [AW-1:0] rd_idx;
   logic          rd_read;
   logic          rd_io;
   logic [31:0]   rd_word;
   logic [3:0]    leds_q;
   logic          unused_addr_bits;

   assign accept  = req_valid && ready_q && (state_q == IDLE) && !reset;
   assign acc_idx = req_addr[AW+1:2];

`ifdef MEM_RESPONDER_IO_EN
   assign acc_io = req_addr[31];

   always_ff @(posedge clk_in) begin
      if (reset) begin
         leds_q <= 4'b0000;
      end else if (accept && acc_io && req_wmask[0]) begin
         leds_q <= req_wdata[3:0];
      end
   end
`else
   assign acc_io = 1'b0;
   assign leds_q = 4'b0000;
`endif

   assign leds             = leds_q;
   assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

   // With zero wait states the read happens on the accept edge itself, so use the live request.
   assign rd_idx  = (state_q == IDLE) ? acc_idx : idx_q;
   assign rd_read = (state_q == IDLE) ? (req_wmask == 4'b0000) : read_q;
   assign rd_io   = (state_q == IDLE) ? acc_io : io_q;

   always_comb begin
      rd_word = 32'h0000_0000;
      if (rd_read) begin
         rd_word = rd_io ? {28'b0, leds_q} : ram_q[rd_idx];
      end
   end

   // RAM holds its contents across reset; writes commit on the accept edge.
   always_ff @(posedge clk_in) begin
      if (accept && !acc_io) begin
         for (int b = 0; b < 4; b++) begin
            if (req_wmask[b]) begin
               ram_q[acc_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         rdata_q <= 32'h0000_0000;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         read_q  <= 1'b0;
         io_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  ready_q <= 1'b0;
                  idx_q   <= acc_idx;
                  read_q  <= (req_wmask == 4'b0000);
                  io_q    <= acc_io;
                  if (WAIT_STATES == 0) begin
                     state_q <= RESP;
                     valid_q <= 1'b1;
                     rdata_q <= rd_word;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= 4'(WAIT_STATES);
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= RESP;
                  valid_q <= 1'b1;
                  rdata_q <= rd_word;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  rdata_q <= 32'h0000_0000;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array memory model.
// Covers the LED register path when MEM_RESPONDER_IO_EN is defined.
module tb_mem_responder;
   localparam int DEPTH = 256;
   localparam int WS    = 1;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_ready;
   logic [3:0]  leds;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem_m [DEPTH];
   logic [3:0]  leds_m;

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .clk_in(clk_in), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ready(resp_ready),
      .leds(leds)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_io(input logic [31:0] a);
`ifdef MEM_RESPONDER_IO_EN
      return a[31];
`else
      return 1'b0;
`endif
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   // Full transaction; caller is positioned 1 time unit after a rising edge with the DUT idle.
   task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input int hold, input bit poke);
      logic [31:0] exp_rd;
      logic [31:0] first_rd;
      int          n;
      exp_rd = 32'h0;
      if (m == 4'b0000) exp_rd = is_io(a) ? {28'b0, leds_m} : mem_m[widx(a)];

      req_valid = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk_in); #1; n++; end
      check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
      @(posedge clk_in); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);

      n = 1;
      while (!resp_valid && n < 40) begin
         check("req_ready_in_wait", {31'b0, req_ready}, 32'd0);
         @(posedge clk_in); #1; n++;
      end
      check("latency", 32'(n), 32'(1 + WS));
      first_rd = resp_rdata;
      check("resp_rdata", resp_rdata, exp_rd);

      for (int h = 0; h < hold; h++) begin
         if (poke) begin
            req_valid = 1'b1; req_addr = 32'h0000_007C; req_wdata = $urandom; req_wmask = 4'hF;
         end
         @(posedge clk_in); #1;
         check("hold_valid", {31'b0, resp_valid}, 32'd1);
         check("hold_rdata", resp_rdata, first_rd);
         check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk_in); #1;
      resp_ready = 1'b0;
      check("post_hs_valid", {31'b0, resp_valid}, 32'd0);
      check("post_hs_ready", {31'b0, req_ready}, 32'd1);

      if (m != 4'b0000) begin
         if (is_io(a)) begin
            if (m[0]) leds_m = d[3:0];
         end else begin
            for (int b = 0; b < 4; b++)
               if (m[b]) mem_m[widx(a)][8*b +: 8] = d[8*b +: 8];
         end
      end
      check("leds", {28'b0, leds}, {28'b0, leds_m});
      $display("[TB] %s addr=%h wdata=%h wmask=%h rdata=%h hold=%0d",
               (m == 4'b0000) ? "RD" : "WR", a, d, m, first_rd, hold);
   endtask

   initial begin
      logic [31:0] ra;
      reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      req_wmask = 4'h0; resp_ready = 1'b0; leds_m = 4'h0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_leds", {28'b0, leds}, 32'd0);
      reset = 1'b0;
      @(posedge clk_in); #1;
      check("ready_after_reset", {31'b0, req_ready}, 32'd1);

      // Give every word a known value so later random reads have defined expectations.
      for (int i = 0; i < DEPTH; i++) do_txn(32'(i * 4), $urandom, 4'hF, 0, 1'b0);

      do_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
      do_txn(32'h10, 32'h0, 4'h0, 0, 1'b0);
      check("dir_deadbeef", mem_m[4], 32'hDEADBEEF);

      do_txn(32'h20, 32'h11223344, 4'hF, 0, 1'b0);
      do_txn(32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0);
      do_txn(32'h20, 32'h0, 4'h0, 0, 1'b0);
      check("dir_partial", mem_m[8], 32'h11BB33DD);

      do_txn(32'h20, 32'h0, 4'h0, 5, 1'b1);

      do_txn(32'h400, 32'h5A5A5A5A, 4'hF, 0, 1'b0);
      do_txn(32'h000, 32'h0, 4'h0, 0, 1'b0);
      do_txn(32'h003, 32'h0, 4'h0, 0, 1'b0);

      // Reset during the wait of a read drops the response.
      do_txn(32'h44, 32'hC0FFEE11, 4'hF, 0, 1'b0);
      req_valid = 1'b1; req_addr = 32'h44; req_wmask = 4'h0;
      @(posedge clk_in); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
         @(posedge clk_in); #1;
      end
      check("rst_mid_ready", {31'b0, req_ready}, 32'd0);
      reset = 1'b0;
      @(posedge clk_in); #1;
      check("rst_mid_ready_after", {31'b0, req_ready}, 32'd1);
      check("rst_mid_valid_after", {31'b0, resp_valid}, 32'd0);
      leds_m = 4'h0;
      do_txn(32'h44, 32'h0, 4'h0, 0, 1'b0);

      do_txn(32'h0, 32'h0, 4'h0, 0, 1'b0);
      do_txn(32'h8000_0000, 32'h0000_000B, 4'b0001, 0, 1'b0);
      do_txn(32'h8000_0000, 32'h0, 4'h0, 0, 1'b0);
      do_txn(32'h0, 32'h0, 4'h0, 0, 1'b0);
`ifdef MEM_RESPONDER_IO_EN
      check("leds_io", {28'b0, leds}, 32'hB);
`else
      check("leds_tied", {28'b0, leds}, 32'h0);
`endif

      for (int i = 0; i < 80; i++) begin
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) ra[31] = 1'b0;
         do_txn(ra, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
